// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// State enumeration, default timing parameters and the set-LEDs command code.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  localparam int RTS_CYCLES_DEF = 10000;
  localparam int FILTER_LEN_DEF = 8;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

  // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the sampled PS/2 clock line; a level is accepted only after
// FILTER_LEN identical samples, and fall_tick pulses once per accepted 1->0.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic ps2c_filt,
  output logic fall_tick
);

  logic [FILTER_LEN-1:0] samples;
  logic [FILTER_LEN-1:0] next_samples;

  assign next_samples = {samples[FILTER_LEN-2:0], ps2c_in};

  // Reset primes the history to the released (high) level so no false edge appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samples   <= '1;
      ps2c_filt <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      samples   <= next_samples;
      fall_tick <= 1'b0;
      if (&next_samples) begin
        ps2c_filt <= 1'b1;
      end else if (~|next_samples) begin
        if (ps2c_filt) fall_tick <= 1'b1;
        ps2c_filt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 11-bit frame, ACK).
// Define PS2_TX_ACK_CHECK_EN to add the sticky ack_err output.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES = RTS_CYCLES_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick
`ifdef PS2_TX_ACK_CHECK_EN
  ,
  output logic       ack_err
`endif
);

  localparam int RTS_W = $clog2(RTS_CYCLES + 1);
  localparam logic [RTS_W-1:0] RTS_LAST   = RTS_W'(RTS_CYCLES - 1);
  localparam logic [RTS_W-1:0] RTS_PENULT = RTS_W'(RTS_CYCLES - 2);

  tx_state_t        state;
  logic [8:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic [RTS_W-1:0] rts_cnt;
  logic             ps2c_filt;
  logic             fall_tick;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .ps2c_filt(ps2c_filt),
    .fall_tick(fall_tick)
  );

  assign tx_idle = (state == IDLE);

  // shift_reg[0] is always the bit currently on the wire; parity sits in bit 8.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      rts_cnt      <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_err      <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ps2) begin
            shift_reg <= {odd_parity(din), din};
            rts_cnt   <= '0;
            bit_cnt   <= '0;
            ps2c_oe   <= 1'b1;
            ps2d_oe   <= 1'b0;
            state     <= RTS;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_err   <= 1'b0;
`endif
          end
        end
        RTS: begin
          rts_cnt <= rts_cnt + 1'b1;
          if (rts_cnt == RTS_PENULT) ps2d_oe <= 1'b1;
          if (rts_cnt == RTS_LAST) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (fall_tick) begin
            ps2d_oe <= ~shift_reg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          // bit_cnt == 8 means parity has been on the wire for one edge already.
          if (fall_tick) begin
            if (bit_cnt == 4'd8) begin
              ps2d_oe <= 1'b0;
              state   <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 4'd1;
              shift_reg <= {1'b0, shift_reg[8:1]};
              ps2d_oe   <= ~shift_reg[1];
            end
          end
        end
        STOP: begin
          if (fall_tick) state <= ACK;
        end
        ACK: begin
          if (fall_tick) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (ps2d_in) ack_err <= 1'b1;
`endif
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (ps2c_filt && ps2d_in) begin
            tx_done_tick <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a keyboard model clocks frames out of the host
// and captured bits are compared against frames built from the byte value.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int RTS  = 50;
  localparam int FLEN = 8;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick;
`ifdef PS2_TX_ACK_CHECK_EN
  logic       ack_err;
`endif

  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Open-drain bus with pull-ups: either side pulling makes the line low.
  assign ps2c_in = ~(ps2c_oe | dev_clk_low);
  assign ps2d_in = ~(ps2d_oe | dev_data_low);

  always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt++;

  ps2_tx #(
    .RTS_CYCLES(RTS),
    .FILTER_LEN(FLEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick)
`ifdef PS2_TX_ACK_CHECK_EN
    ,
    .ack_err     (ack_err)
`endif
  );

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic pulse_wr(input logic [7:0] d);
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Keyboard model: measures RTS, then generates 12 clocks, sampling on high phases.
  task automatic run_frame(input logic [7:0] d, input bit ack_high, input int abort_at,
                           input bit inject, output int rts_len, output logic [1:0] rts_d,
                           output logic start_ok, output logic [10:0] bits,
                           output int dones, output logic ack_after_wr);
    int d0;
    d0 = done_cnt;
    bits = '0;
    dones = 0;
    pulse_wr(d);
`ifdef PS2_TX_ACK_CHECK_EN
    ack_after_wr = ack_err;
`else
    ack_after_wr = 1'b0;
`endif
    rts_len = 0;
    rts_d = 2'b00;
    while (ps2c_oe === 1'b1 && rts_len < 4 * RTS) begin
      rts_d = {rts_d[0], ps2d_oe};
      rts_len++;
      @(negedge clk);
    end
    start_ok = (ps2c_oe === 1'b0) && (ps2d_oe === 1'b1);
    repeat (HALF) @(negedge clk);
    bits[0] = ps2d_in;
    for (int k = 1; k <= 12; k++) begin
      dev_clk_low = 1'b1;
      if (inject && k == 3) begin
        pulse_wr(8'h55);
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      if (k == 12) dev_data_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      if (k <= 10) bits[k] = ps2d_in;
      if (k == 10) dev_data_low = ~ack_high;
      if (k == abort_at) return;
      repeat (HALF / 2) @(negedge clk);
    end
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0010", {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick});
    end
`ifdef PS2_TX_ACK_CHECK_EN
    vectors++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ack_err: got %b expected 0", ack_err);
    end
`endif
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame(input logic [7:0] d, input string name);
    int rl, dn;
    logic [1:0] rd;
    logic so, aw;
    logic [10:0] bits;
    run_frame(d, 1'b0, 0, 1'b0, rl, rd, so, bits, dn, aw);
    vectors++;
    if (rl != RTS) begin
      errors++;
      $display("[TB] FAIL %s rts_len: got %0d expected %0d", name, rl, RTS);
    end
    vectors++;
    if (rd !== 2'b01) begin
      errors++;
      $display("[TB] FAIL %s rts_data_tail: got %b expected 01", name, rd);
    end
    vectors++;
    if (so !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s start_lines: got %b expected 1", name, so);
    end
    vectors++;
    if (bits !== frame_of(d)) begin
      errors++;
      $display("[TB] FAIL %s frame: got %b expected %b", name, bits, frame_of(d));
    end
    vectors++;
    if (dn != 1) begin
      errors++;
      $display("[TB] FAIL %s done_ticks: got %0d expected 1", name, dn);
    end
    vectors++;
    if (tx_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s idle_after: got %b expected 1", name, tx_idle);
    end
`ifdef PS2_TX_ACK_CHECK_EN
    vectors++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s ack_err: got %b expected 0", name, ack_err);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom_range(0, 255));
      test_frame(d, "random");
    end
  endtask

  task automatic test_ack_error();
    int rl, dn;
    logic [1:0] rd;
    logic so, aw;
    logic [10:0] bits;
    run_frame(8'h3C, 1'b1, 0, 1'b0, rl, rd, so, bits, dn, aw);
    vectors++;
    if (dn != 1) begin
      errors++;
      $display("[TB] FAIL nack_done_ticks: got %0d expected 1", dn);
    end
    vectors++;
    if (bits !== frame_of(8'h3C)) begin
      errors++;
      $display("[TB] FAIL nack_frame: got %b expected %b", bits, frame_of(8'h3C));
    end
`ifdef PS2_TX_ACK_CHECK_EN
    vectors++;
    if (ack_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nack_ack_err_set: got %b expected 1", ack_err);
    end
`endif
    run_frame(8'hA5, 1'b0, 0, 1'b0, rl, rd, so, bits, dn, aw);
`ifdef PS2_TX_ACK_CHECK_EN
    vectors++;
    if (aw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_err_clear_on_wr: got %b expected 0", aw);
    end
`endif
    vectors++;
    if (bits !== frame_of(8'hA5) || dn != 1) begin
      errors++;
      $display("[TB] FAIL after_nack_frame: got %b/%0d expected %b/1", bits, dn, frame_of(8'hA5));
    end
  endtask

  task automatic test_reset_mid_frame();
    int rl, dn, d0, busy;
    logic [1:0] rd;
    logic so, aw;
    logic [10:0] bits;
    run_frame(8'h9A, 1'b0, 4, 1'b0, rl, rd, so, bits, dn, aw);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_release: got %b expected 00", {ps2c_oe, ps2d_oe});
    end
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_idle !== 1'b1) busy++;
    end
    vectors++;
    if (done_cnt != d0 || busy != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got done %0d busy %0d expected done 0 busy 0", done_cnt - d0, busy);
    end
    test_frame(8'hF4, "after_abort");
  endtask

  task automatic test_wr_during_data();
    int rl, dn, stray;
    logic [1:0] rd;
    logic so, aw;
    logic [10:0] bits;
    run_frame(8'hC3, 1'b0, 0, 1'b1, rl, rd, so, bits, dn, aw);
    vectors++;
    if (bits !== frame_of(8'hC3)) begin
      errors++;
      $display("[TB] FAIL inject_frame: got %b expected %b", bits, frame_of(8'hC3));
    end
    stray = 0;
    for (int i = 0; i < 3 * RTS; i++) begin
      @(negedge clk);
      if (ps2c_oe !== 1'b0 || tx_idle !== 1'b1) stray++;
    end
    vectors++;
    if (dn != 1 || stray != 0) begin
      errors++;
      $display("[TB] FAIL inject_single_frame: got done %0d stray %0d expected done 1 stray 0", dn, stray);
    end
  endtask

  initial begin
    test_reset();
    test_frame(PS2_CMD_SET_LEDS, "set_leds");
    test_frame(8'h01, "byte_01");
    test_frame(8'hFF, "byte_ff");
    test_random();
    test_ack_error();
    test_reset_mid_frame();
    test_wr_during_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameters SHALL be: RTS_CYCLES, 10000, host clock-inhibit length in clk cycles (100 us at 100 MHz); FILTER_LEN, 8, ps2c_in stable samples needed to accept a level.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_ps2  input  1  one-cycle start request; din is captured in the same cycle.
REQ-005 din  input  8  command byte to send to the keyboard, e.g. 0xED (set LEDs).
REQ-006 ps2c_in, ps2d_in  input  1 each  sampled PS/2 clock and data lines.
REQ-007 ps2c_oe, ps2d_oe  output  1 each  open-drain enables; 1 pulls the line low, 0 releases it.
REQ-008 tx_idle  output  1  high only in IDLE; receive logic is gated by it.
REQ-009 tx_done_tick  output  1  one-cycle pulse at end of frame.
REQ-010 ack_err  output  1  sticky until next wr_ps2; present only with PS2_TX_ACK_CHECK_EN.

Function
REQ-011 States SHALL be IDLE, RTS, START, DATA, STOP, ACK, WAIT_IDLE.
REQ-012 IDLE: wr_ps2=1 SHALL load shift register {odd_parity(din), din}, with odd_parity = ~^din, and move to RTS next cycle.
REQ-013 wr_ps2 outside IDLE SHALL be ignored, with no effect on the frame in progress.
REQ-014 RTS: ps2c_oe=1 for exactly RTS_CYCLES cycles, then START; ps2d_oe SHALL assert on the final RTS cycle.
REQ-015 START: ps2c_oe=0, ps2d_oe=1 (start bit 0); on the first filtered ps2c falling edge go to DATA, driving bit 0.
REQ-016 DATA: each falling edge SHALL shift to the next bit, LSB first, 8 data bits then parity; ps2d_oe = ~current_bit.
REQ-017 After the parity bit has been presented for one falling edge, ps2d_oe SHALL go 0 (stop bit) and the FSM SHALL enter STOP.
REQ-018 STOP: on the next falling edge go to ACK.
REQ-019 ACK: on the next falling edge, sample ps2d_in (0 = ACK); go to WAIT_IDLE.
REQ-020 WAIT_IDLE: when filtered ps2c_in=1 and ps2d_in=1, pulse tx_done_tick for 1 cycle and return to IDLE.
REQ-021 Falling edge = filtered ps2c transitions 1->0; edges SHALL be ignored in IDLE and RTS.
REQ-022 Both oe outputs SHALL be 0 in IDLE, STOP, ACK and WAIT_IDLE.
REQ-023 Bit counter SHALL be 4 bits, count 0..8, and never wrap within a frame.

Reset
REQ-024 Reset SHALL force state IDLE, ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, ack_err=0, shift register and counters 0, and the filter primed to the released level 1.
REQ-025 Reset mid-frame SHALL release both lines in the same cycle (asynchronous) and emit no tx_done_tick.

Configuration
REQ-026 With macro PS2_TX_ACK_CHECK_EN defined, ack_err SHALL be set when ps2d_in=1 at the ACK sample and cleared on the next accepted wr_ps2.
REQ-027 Without PS2_TX_ACK_CHECK_EN, the ack_err port and logic SHALL be absent and the ACK sample value SHALL be ignored; state sequencing SHALL be identical.

Structure
REQ-028 Package ps2_pkg SHALL hold the state enumeration, the default RTS_CYCLES and FILTER_LEN values, and the constant PS2_CMD_SET_LEDS = 8'hED.
REQ-029 Sub-module ps2_clk_filter SHALL provide the filtered ps2c level and a one-cycle fall_tick; ps2_tx SHALL instantiate it once.

Verification
REQ-030 Send din=0xED with a device model acknowledging: data bits 1,0,1,1,0,1,1,1, parity 1; tx_done_tick exactly once; ack_err=0.
REQ-031 din=0x01: parity 0; din=0xFF: parity 1. The bench SHALL check the sampled frames bit for bit.
REQ-032 RTS check: ps2c_oe high for exactly RTS_CYCLES (test value 50), then ps2d_oe=1 and ps2c_oe=0.
REQ-033 Device holds data high at ACK: with macro, ack_err=1 after the frame and cleared by the next wr_ps2; without macro, tx_done_tick still occurs.
REQ-034 Assert reset after the 4th data bit: both oe=0 immediately; no tx_done_tick; a new wr_ps2 of 0xF4 completes normally.
REQ-035 wr_ps2 pulsed during DATA with din=0x55: the frame in progress is unchanged, and only one frame is sent.
